bf16_to_int: RTL and testbench

Pipelined converter from BFloat16 to a signed two's-complement integer, truncating toward zero with saturation and IEEE-style exception flags. It is the decode direction of the integer-to-BFloat16 normalization path, which counts leading zeros and shifts left. This block instead unpacks the exponent and shifts the significand into integer position. It sits at the FP unit output, between the BF16 result bus and integer consumers, with valid/ready handshakes on both sides.

---
 rtl/bf16_to_int.sv | 157 +++++++++++++++
 tb/tb_bf16_to_int.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_to_int.sv
// Two-stage BFloat16 to signed integer converter: round toward zero, saturate,
// raise inexact/overflow/invalid flags. Valid/ready handshake on both sides.
module bf16_to_int #(
  parameter int unsigned I_W = 16
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [15:0]    data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [I_W-1:0] int_o,
  output logic           nx_o,
  output logic           of_o,
  output logic           nv_o
);

  if (I_W < 9 || I_W > 32) begin : g_bad_width
    $error("bf16_to_int: I_W must be within 9..32");
  end

  typedef enum logic [2:0] {
    CL_ZERO,
    CL_NAN,
    CL_INF,
    CL_UNDER,
    CL_SHR,
    CL_SHL,
    CL_OVF
  } cls_t;

  localparam logic signed [9:0] EMAX = 10'(I_W - 1);

  // Handshake: each stage loads when empty or when the stage after it moves.
  logic v1, v2;
  logic en1, en2;

  assign en2     = !v2 || ready_i;
  assign en1     = !v1 || en2;
  assign ready_o = en1;
  assign valid_o = v2;

  // ---------------------------------------------------------------- stage 1
  logic                   s_in;
  logic [7:0]             e_in;
  logic [6:0]             m_in;
  logic signed [9:0]      exp_unb;
  cls_t                   cls_d;
  logic [7:0]             sig_d;
  logic [4:0]             sh_d;

  assign s_in    = data_i[15];
  assign e_in    = data_i[14:7];
  assign m_in    = data_i[6:0];
  assign exp_unb = signed'({2'b00, e_in}) - 10'sd127;

  always_comb begin
    cls_d = CL_ZERO;
    sig_d = {1'b1, m_in};
    sh_d  = '0;
    if (e_in == 8'h00) begin
      // No hidden bit: a nonzero sig1 later marks a discarded subnormal.
      cls_d = CL_ZERO;
      sig_d = {1'b0, m_in};
    end else if (e_in == 8'hFF) begin
      cls_d = (m_in != 7'd0) ? CL_NAN : CL_INF;
    end else if (exp_unb < 10'sd0) begin
      cls_d = CL_UNDER;
    end else if (exp_unb <= 10'sd7) begin
      cls_d = CL_SHR;
      sh_d  = 5'(10'sd7 - exp_unb);
    end else if (exp_unb < EMAX || (exp_unb == EMAX && s_in && m_in == 7'd0)) begin
      cls_d = CL_SHL;
      sh_d  = 5'(exp_unb - 10'sd7);
    end else begin
      cls_d = CL_OVF;
    end
  end

  logic       s1;
  cls_t       cls1;
  logic [7:0] sig1;
  logic [4:0] sh1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v1   <= 1'b0;
      s1   <= 1'b0;
      cls1 <= CL_ZERO;
      sig1 <= '0;
      sh1  <= '0;
    end else if (en1) begin
      v1 <= valid_i;
      if (valid_i) begin
        s1   <= s_in;
        cls1 <= cls_d;
        sig1 <= sig_d;
        sh1  <= sh_d;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [I_W-1:0] mag;
  logic [I_W-1:0] res_d;
  logic [7:0]     drop_mask;
  logic           nx_d, of_d, nv_d;

  always_comb begin
    mag       = '0;
    res_d     = '0;
    drop_mask = '0;
    nx_d      = 1'b0;
    of_d      = 1'b0;
    nv_d      = 1'b0;
    case (cls1)
      CL_ZERO:  nx_d = |sig1;
      CL_NAN:   nv_d = 1'b1;
      CL_INF:   of_d = 1'b1;
      CL_OVF:   of_d = 1'b1;
      CL_UNDER: nx_d = 1'b1;
      CL_SHR: begin
        mag       = I_W'(sig1 >> sh1[2:0]);
        drop_mask = ~(8'hFF << sh1[2:0]);
        nx_d      = |(sig1 & drop_mask);
      end
      CL_SHL:   mag = I_W'(sig1) << sh1;
      default:  mag = '0;
    endcase
    if (of_d) begin
      res_d = s1 ? {1'b1, {(I_W-1){1'b0}}} : {1'b0, {(I_W-1){1'b1}}};
    end else begin
      // -2^(I_W-1) is reached by negating a magnitude that fills the MSB.
      res_d = s1 ? (~mag + 1'b1) : mag;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v2    <= 1'b0;
      int_o <= '0;
      nx_o  <= 1'b0;
      of_o  <= 1'b0;
      nv_o  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        int_o <= res_d;
        nx_o  <= nx_d;
        of_o  <= of_d;
        nv_o  <= nv_d;
      end
    end
  end

endmodule

// File: tb/tb_bf16_to_int.sv
// Self-checking bench: three widths (16, 9, 32) driven in lockstep, directed
// spec values plus a randomized stream scored against a value-level model.
module tb_bf16_to_int;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] data_i = '0;

  logic        rdy16, rdy9, rdy32;
  logic        vo16, vo9, vo32;
  logic [15:0] int16;
  logic [8:0]  int9;
  logic [31:0] int32;
  logic        nx16, of16, nv16, nx9, of9, nv9, nx32, of32, nv32;

  int checks = 0;
  int failures = 0;
  int ins = 0;
  int outs = 0;
  logic [15:0] q[$];

  bf16_to_int #(.I_W(16)) dut16 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(rdy16), .data_i(data_i),
    .valid_o(vo16), .ready_i(ready_i), .int_o(int16), .nx_o(nx16), .of_o(of16), .nv_o(nv16));

  bf16_to_int #(.I_W(9)) dut9 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(rdy9), .data_i(data_i),
    .valid_o(vo9), .ready_i(ready_i), .int_o(int9), .nx_o(nx9), .of_o(of9), .nv_o(nv9));

  bf16_to_int #(.I_W(32)) dut32 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(rdy32), .data_i(data_i),
    .valid_o(vo32), .ready_i(ready_i), .int_o(int32), .nx_o(nx32), .of_o(of32), .nv_o(nv32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Value-level model: exact value, truncate toward zero, then range-check.
  function automatic void ref_conv(input logic [15:0] d, input int w,
                                   output longint v, output logic [2:0] fl);
    int     ex;
    longint sig, mag, lim;
    fl  = '0;
    v   = 0;
    ex  = int'(d[14:7]) - 127;
    sig = 128 + longint'(d[6:0]);
    lim = longint'(1) << (w - 1);
    if (d[14:7] == 8'd0) begin
      fl[2] = (d[6:0] != 7'd0);
      return;
    end
    if (d[14:7] == 8'hFF) begin
      if (d[6:0] != 7'd0) begin
        fl[0] = 1'b1;
        return;
      end
      v     = d[15] ? -lim : lim - 1;
      fl[1] = 1'b1;
      return;
    end
    if (ex < 0) begin
      fl[2] = 1'b1;
      return;
    end
    if (ex <= 7) begin
      mag   = sig / (longint'(1) << (7 - ex));
      fl[2] = ((mag << (7 - ex)) != sig);
    end else begin
      if (ex > 40) ex = 40;
      mag = sig * (longint'(1) << (ex - 7));
    end
    v = d[15] ? -mag : mag;
    if (v > lim - 1) begin
      v  = lim - 1;
      fl = 3'b010;
    end else if (v < -lim) begin
      v  = -lim;
      fl = 3'b010;
    end
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [7:0] e;
    logic [6:0] m;
    int k;
    k = $urandom_range(0, 9);
    m = 7'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k <= 7) e = 8'($urandom_range(118, 160));
    else e = 8'($urandom);
    if ($urandom_range(0, 3) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // Scoreboard: inputs pushed on transfer, every presented result checked.
  always @(negedge clk) begin
    longint   v;
    logic [2:0] fl;
    if (nreset) begin
      if (valid_i && rdy16) begin
        q.push_back(data_i);
        ins++;
      end
      if (vo16) begin
        chk("q_nonempty", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          ref_conv(q[0], 16, v, fl);
          chk("int16", $signed(int16), v);
          chk("flags16", {nx16, of16, nv16}, fl);
          ref_conv(q[0], 9, v, fl);
          chk("valid9", vo9, 1);
          chk("int9", $signed(int9), v);
          chk("flags9", {nx9, of9, nv9}, fl);
          ref_conv(q[0], 32, v, fl);
          chk("valid32", vo32, 1);
          chk("int32", $signed(int32), v);
          chk("flags32", {nx32, of32, nv32}, fl);
          if (ready_i) begin
            void'(q.pop_front());
            outs++;
          end
        end
      end
    end
  end

  task automatic run_one(input logic [15:0] d, input longint e16, input logic [2:0] f16,
                         input int xw, input longint xv, input logic [2:0] xf);
    @(posedge clk); #1;
    valid_i = 1'b1;
    data_i  = d;
    ready_i = 1'b1;
    @(negedge clk);
    chk("accept", rdy16, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("lat_early", vo16, 0);
    @(negedge clk);
    chk("lat_valid", vo16, 1);
    chk("d_int16", $signed(int16), e16);
    chk("d_flags16", {nx16, of16, nv16}, f16);
    if (xw == 9) begin
      chk("d_int9", $signed(int9), xv);
      chk("d_flags9", {nx9, of9, nv9}, xf);
    end else if (xw == 32) begin
      chk("d_int32", $signed(int32), xv);
      chk("d_flags32", {nx32, of32, nv32}, xf);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  cyc;
    logic xfer;

    // Reset state
    #2;
    chk("rst_valid", vo16, 0);
    chk("rst_int", int16, 0);
    chk("rst_flags", {nx16, of16, nv16}, 0);
    #10;
    nreset = 1'b1;
    #1;
    chk("rst_ready16", rdy16, 1);
    chk("rst_ready9", rdy9, 1);
    chk("rst_ready32", rdy32, 1);

    // Basic values and specials; {nx,of,nv}
    run_one(16'h3F80, 1,      3'b000, 0,  0,          3'b000);
    run_one(16'hC020, -2,     3'b100, 0,  0,          3'b000);
    run_one(16'h46FF, 32640,  3'b000, 0,  0,          3'b000);
    run_one(16'h3F00, 0,      3'b100, 0,  0,          3'b000);
    run_one(16'h4700, 32767,  3'b010, 0,  0,          3'b000);
    run_one(16'hC700, -32768, 3'b000, 0,  0,          3'b000);
    run_one(16'hC780, -32768, 3'b010, 0,  0,          3'b000);
    run_one(16'h7F80, 32767,  3'b010, 0,  0,          3'b000);
    run_one(16'h7FC0, 0,      3'b001, 0,  0,          3'b000);
    run_one(16'h8000, 0,      3'b000, 0,  0,          3'b000);
    run_one(16'h4380, 256,    3'b000, 9,  255,        3'b010);
    run_one(16'hC380, -256,   3'b000, 9,  -256,       3'b000);
    run_one(16'h4EFF, 32767,  3'b010, 32, 2139095040, 3'b000);

    // Backpressure: two accepted, third waits for the release edge
    @(posedge clk); #1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 16'h4040;
    @(negedge clk);
    chk("bp_rdy_a", rdy16, 1);
    @(posedge clk); #1;
    data_i = 16'hC0E0;
    @(negedge clk);
    chk("bp_rdy_b", rdy16, 1);
    @(posedge clk); #1;
    data_i = 16'h4316;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full", rdy16, 0);
      chk("bp_valid", vo16, 1);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release", rdy16, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_drained", q.size(), 0);

    // Random stream
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      xfer = valid_i && rdy16;
      @(posedge clk); #1;
      cyc++;
      if (xfer) sent++;
      if (xfer || !valid_i) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = rand_bf16();
      end
      ready_i = ($urandom_range(0, 2) != 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("rand_sent", sent, 1000);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("rand_drain", q.size(), 0);
    chk("io_count", outs, ins);

    // Reset mid-flight
    @(posedge clk); #1;
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 16'h4700;
    @(posedge clk); #1;
    data_i = 16'h3F80;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", vo16, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_valid16", vo16, 0);
    chk("mid_rst_int16", int16, 0);
    chk("mid_rst_flags16", {nx16, of16, nv16}, 0);
    chk("mid_rst_valid9", vo9, 0);
    chk("mid_rst_int32", int32, 0);
    chk("mid_rst_flags32", {nx32, of32, nv32}, 0);
    ins = ins - q.size();
    q.delete();
    @(posedge clk); #1;
    nreset = 1'b1;
    #1;
    chk("post_rst_ready", rdy16, 1);
    run_one(16'h4000, 2, 3'b000, 32, 2, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("final_empty", q.size(), 0);
    chk("final_count", outs, ins);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
